// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - memory-mapped 8-digit seven-segment scan controller
// Store data lands in digit/control registers; two 4-digit groups are scanned together.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 25000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        seg_we,
  input  logic [1:0]  seg_addr,
  input  logic [15:0] seg_wdata,
  output logic [7:0]  seg_out0,
  output logic [7:0]  seg_out1,
  output logic [7:0]  tub_sel,
  output logic        frame_tick
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [15:0]      dig_lo;
  logic [15:0]      dig_hi;
  logic [7:0]       blank;
  logic [7:0]       dp;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       slot;
  logic             slot_end;

  logic [15:0] lo_sh;
  logic [15:0] hi_sh;
  logic [7:0]  hex_lo;
  logic [7:0]  hex_hi;
  logic [2:0]  idx_lo;
  logic [2:0]  idx_hi;
  logic [7:0]  seg0_nxt;
  logic [7:0]  seg1_nxt;
  logic [7:0]  tub_nxt;
  logic        frame_nxt;

  // Segment pattern {a..g, dp} with dp cleared; dp is merged in by the caller.
  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_seg = 8'hFC;
      4'h1:    hex_seg = 8'h60;
      4'h2:    hex_seg = 8'hDA;
      4'h3:    hex_seg = 8'hF2;
      4'h4:    hex_seg = 8'h66;
      4'h5:    hex_seg = 8'hB6;
      4'h6:    hex_seg = 8'hBE;
      4'h7:    hex_seg = 8'hE0;
      4'h8:    hex_seg = 8'hFE;
      4'h9:    hex_seg = 8'hF6;
      4'hA:    hex_seg = 8'hEE;
      4'hB:    hex_seg = 8'h3E;
      4'hC:    hex_seg = 8'h9C;
      4'hD:    hex_seg = 8'h7A;
      4'hE:    hex_seg = 8'h9E;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  assign slot_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dig_lo <= 16'h0000;
      dig_hi <= 16'h0000;
      blank  <= 8'hFF;
      dp     <= 8'h00;
    end else if (seg_we) begin
      case (seg_addr)
        2'd0:    dig_lo <= seg_wdata;
        2'd1:    dig_hi <= seg_wdata;
        2'd2: begin
          blank <= seg_wdata[15:8];
          dp    <= seg_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // Free-running scan; writes never touch it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      slot    <= 2'd0;
    end else if (slot_end) begin
      div_cnt <= '0;
      slot    <= slot + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    lo_sh     = dig_lo >> {slot, 2'b00};
    hi_sh     = dig_hi >> {slot, 2'b00};
    idx_lo    = {1'b0, slot};
    idx_hi    = {1'b1, slot};
    hex_lo    = hex_seg(lo_sh[3:0]);
    hex_hi    = hex_seg(hi_sh[3:0]);
    seg0_nxt  = blank[idx_lo] ? 8'h00 : {hex_lo[7:1], dp[idx_lo]};
    seg1_nxt  = blank[idx_hi] ? 8'h00 : {hex_hi[7:1], dp[idx_hi]};
    tub_nxt   = 8'h00;
    tub_nxt[idx_lo] = ~blank[idx_lo];
    tub_nxt[idx_hi] = ~blank[idx_hi];
    frame_nxt = slot_end && (slot == 2'd3);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_out0   <= 8'h00;
      seg_out1   <= 8'h00;
      tub_sel    <= 8'h00;
      frame_tick <= 1'b0;
    end else begin
      seg_out0   <= seg0_nxt;
      seg_out1   <= seg1_nxt;
      tub_sel    <= tub_nxt;
      frame_tick <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl with SCAN_DIV=4
// Expected output sets are queued against a cycle number; the monitor pops them.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        seg_we = 1'b0;
  logic [1:0]  seg_addr = 2'd0;
  logic [15:0] seg_wdata = 16'h0000;
  logic [7:0]  seg_out0;
  logic [7:0]  seg_out1;
  logic [7:0]  tub_sel;
  logic        frame_tick;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         at;
    string      name;
    logic [7:0] tub;
    logic [7:0] s0;
    logic [7:0] s1;
    logic       ft;
  } exp_t;

  exp_t sb[$];

  seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .seg_we     (seg_we),
    .seg_addr   (seg_addr),
    .seg_wdata  (seg_wdata),
    .seg_out0   (seg_out0),
    .seg_out1   (seg_out1),
    .tub_sel    (tub_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void exp_push(input int at, input string name, input logic [7:0] tub,
                                   input logic [7:0] s0, input logic [7:0] s1, input logic ft);
    exp_t e;
    e.at = at; e.name = name; e.tub = tub; e.s0 = s0; e.s1 = s1; e.ft = ft;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t it;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      it = sb.pop_front();
      total++;
      if (it.at < cyc) begin
        bad++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", it.name, cyc, it.at);
      end else if ({tub_sel, seg_out0, seg_out1, frame_tick} !== {it.tub, it.s0, it.s1, it.ft}) begin
        bad++;
        $display("FAIL %s: got tub=%h s0=%h s1=%h ft=%b, want tub=%h s0=%h s1=%h ft=%b",
                 it.name, tub_sel, seg_out0, seg_out1, frame_tick, it.tub, it.s0, it.s1, it.ft);
      end
    end
  end

  // Drive a one-cycle store from the negedge where cyc == c.
  task automatic wr(input int c, input logic [1:0] a, input logic [15:0] d);
    while (cyc < c) @(negedge clk);
    seg_we = 1'b1; seg_addr = a; seg_wdata = d;
    @(negedge clk);
    seg_we = 1'b0;
  endtask

  initial begin
    // release at negedge cyc 2, so scan edge e lands at cyc 2+e
    exp_push(3,  "rst_e1",  8'h00, 8'h00, 8'h00, 1'b0);
    exp_push(5,  "lat_e3",  8'h00, 8'h00, 8'h00, 1'b0);
    exp_push(6,  "t2_s0",   8'h11, 8'hFC, 8'h66, 1'b0);
    exp_push(8,  "t2_s1",   8'h22, 8'h60, 8'hB6, 1'b0);
    exp_push(12, "t2_s2",   8'h44, 8'hDA, 8'hBE, 1'b0);
    exp_push(16, "t2_s3",   8'h88, 8'hF2, 8'hE0, 1'b0);
    exp_push(18, "ft_e16",  8'h88, 8'hF2, 8'hE0, 1'b1);
    exp_push(19, "t2_wrap", 8'h11, 8'hFC, 8'h66, 1'b0);
    exp_push(22, "t3_s0",   8'h11, 8'hFD, 8'h9C, 1'b0);
    exp_push(32, "t3_s3",   8'h88, 8'hF2, 8'h8F, 1'b0);
    exp_push(34, "t3_ft",   8'h88, 8'hF2, 8'h8F, 1'b1);
    exp_push(35, "t3_wrap", 8'h11, 8'hFD, 8'h9C, 1'b0);
    exp_push(38, "t4_s0",   8'h10, 8'h00, 8'h9C, 1'b0);
    exp_push(40, "t4_s1",   8'h20, 8'h00, 8'h7A, 1'b0);
    exp_push(44, "t4_s2",   8'h40, 8'h00, 8'h9E, 1'b0);
    exp_push(48, "t4_s3",   8'h80, 8'h00, 8'h8E, 1'b0);
    exp_push(50, "t4_ft",   8'h80, 8'h00, 8'h8E, 1'b1);
    exp_push(58, "t5_old",  8'h22, 8'h60, 8'h7A, 1'b0);
    exp_push(59, "t5_new",  8'h44, 8'hEF, 8'h9E, 1'b0);
    exp_push(66, "t5_ft",   8'h88, 8'hB6, 8'h8E, 1'b1);
    exp_push(68, "rst_mid", 8'h00, 8'h00, 8'h00, 1'b0);
    exp_push(69, "rst_hold",8'h00, 8'h00, 8'h00, 1'b0);
    exp_push(71, "rst2_e1", 8'h00, 8'h00, 8'h00, 1'b0);
    exp_push(72, "rst2_e2", 8'h11, 8'hFC, 8'hFC, 1'b0);
    exp_push(74, "rst2_e4", 8'h11, 8'hFC, 8'hFC, 1'b0);
    exp_push(75, "rst2_e5", 8'h22, 8'hFC, 8'hFC, 1'b0);

    while (cyc < 2) @(negedge clk);
    rstn = 1'b1;
    wr(2, 2'd0, 16'h3210);
    wr(3, 2'd1, 16'h7654);
    wr(4, 2'd2, 16'h0000);
    wr(18, 2'd1, 16'hFEDC);
    wr(19, 2'd2, 16'h0081);
    wr(36, 2'd2, 16'h0F00);
    wr(40, 2'd3, 16'hFFFF);
    wr(51, 2'd2, 16'h0004);
    wr(57, 2'd0, 16'h5A5A);

    // asynchronous reset in the middle of a slot
    while (cyc < 68) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    while (cyc < 70) @(negedge clk);
    rstn = 1'b1;
    wr(70, 2'd2, 16'h0000);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
